sm83_adr_seq: RTL and testbench

Sequencer for the SM83 address latch/incrementer.
- Accepts address-micro-operations from the instruction decoder over a valid/ready handshake.
- Expands each into one or two steps of incrementer control words: ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe.
- Sits between the decoder and the address latch; these five outputs are the only drivers of the latch controls.

---
 rtl/sm83_adr_pkg.sv | 41 ++++
 rtl/sm83_adr_seq_dec.sv | 31 +++
 rtl/sm83_adr_seq.sv | 89 ++++++++
 tb/tb_sm83_adr_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_adr_pkg.sv
// Shared types for the SM83 address-latch sequencer: op codes, control word, step table.
// Pure declarations; no timing of its own.
// No flow control lives here; see sm83_adr_seq for handshaking.
package sm83_adr_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD     = 3'd1,
        OP_LOAD_HI  = 3'd2,
        OP_INC      = 3'd3,
        OP_DEC      = 3'd4,
        OP_LOAD_INC = 3'd5,
        OP_DEC2     = 3'd6,
        OP_INC2     = 3'd7
    } adr_op_t;

    typedef struct packed {
        logic we;
        logic hi_ff;
        logic dec;
        logic cy;
        logic oe;
    } adr_ctl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2
    } adr_state_t;

    localparam adr_ctl_t CTL_NOP     = 5'b00000;
    localparam adr_ctl_t CTL_LOAD    = 5'b10000;
    localparam adr_ctl_t CTL_LOAD_HI = 5'b11000;
    localparam adr_ctl_t CTL_INC     = 5'b10011;
    localparam adr_ctl_t CTL_DEC     = 5'b10111;

    function automatic logic op_two_step(input adr_op_t op);
        return (op == OP_LOAD_INC) || (op == OP_DEC2) || (op == OP_INC2);
    endfunction

endpackage

// File: rtl/sm83_adr_seq_dec.sv
// Maps (op, step) to the incrementer/latch control word.
// Purely combinational, zero latency.
// No backpressure; caller decides when the word is used.
module sm83_adr_seq_dec
    import sm83_adr_pkg::*;
(
    input  adr_op_t  op_i,
    input  logic     step2_i,
    output adr_ctl_t ctl_o
);

    always_comb begin
        ctl_o = CTL_NOP;
        if (!step2_i) begin
            case (op_i)
                OP_LOAD, OP_LOAD_INC: ctl_o = CTL_LOAD;
                OP_LOAD_HI:           ctl_o = CTL_LOAD_HI;
                OP_INC, OP_INC2:      ctl_o = CTL_INC;
                OP_DEC, OP_DEC2:      ctl_o = CTL_DEC;
                default:              ctl_o = CTL_NOP;
            endcase
        end else begin
            case (op_i)
                OP_LOAD_INC, OP_INC2: ctl_o = CTL_INC;
                OP_DEC2:              ctl_o = CTL_DEC;
                default:              ctl_o = CTL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/sm83_adr_seq.sv
// Expands decoder address micro-ops into one or two latch/incrementer control steps.
// Latency 1: controls for an op accepted at posedge N are driven throughout cycle N+1.
// Ready only on the last step of an op (or idle); stall freezes state and blocks the latch write.
module sm83_adr_seq
    import sm83_adr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    output logic       req_ready,
    input  logic       stall,
    output logic       busy,
    output logic       op_done,
    output logic       ctl_al_we,
    output logic       ctl_al_hi_ff,
    output logic       ctl_inc_dec,
    output logic       ctl_inc_cy,
    output logic       ctl_inc_oe
);

    adr_state_t state_q, state_d;
    adr_op_t    op_q, op_d;
    adr_ctl_t   ctl_q, ctl_d;
    adr_ctl_t   ctl_step1, ctl_step2;
    adr_op_t    req_op_e;
    logic       last_step;
    logic       accept;

    assign req_op_e = adr_op_t'(req_op);

    sm83_adr_seq_dec u_dec_step1 (
        .op_i    (req_op_e),
        .step2_i (1'b0),
        .ctl_o   (ctl_step1)
    );

    sm83_adr_seq_dec u_dec_step2 (
        .op_i    (op_q),
        .step2_i (1'b1),
        .ctl_o   (ctl_step2)
    );

    assign last_step = (state_q == ST_EXEC2) ||
                       ((state_q == ST_EXEC1) && !op_two_step(op_q));
    assign req_ready = ~stall & ((state_q == ST_IDLE) | last_step);
    assign op_done   = ~stall & last_step;
    assign accept    = req_valid & req_ready;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctl_d   = ctl_q;
        if (!stall) begin
            if ((state_q == ST_EXEC1) && op_two_step(op_q)) begin
                state_d = ST_EXEC2;
                ctl_d   = ctl_step2;
            end else if (accept) begin
                state_d = ST_EXEC1;
                op_d    = req_op_e;
                ctl_d   = ctl_step1;
            end else begin
                state_d = ST_IDLE;
                ctl_d   = CTL_NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            ctl_q   <= CTL_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctl_q   <= ctl_d;
        end
    end

    // Only the write strobe is gated: the latch must not capture while the bus waits.
    assign ctl_al_we    = ctl_q.we & ~stall;
    assign ctl_al_hi_ff = ctl_q.hi_ff;
    assign ctl_inc_dec  = ctl_q.dec;
    assign ctl_inc_cy   = ctl_q.cy;
    assign ctl_inc_oe   = ctl_q.oe;

endmodule

// File: tb/tb_sm83_adr_seq.sv
// Scoreboard bench for sm83_adr_seq: driver queues expected steps, negedge monitor checks
// controls and an address-latch model against a golden PC/SP value.
module tb_sm83_adr_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_op;
    logic       req_ready;
    logic       stall;
    logic       busy;
    logic       op_done;
    logic       ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe;

    sm83_adr_seq dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_ready    (req_ready),
        .stall        (stall),
        .busy         (busy),
        .op_done      (op_done),
        .ctl_al_we    (ctl_al_we),
        .ctl_al_hi_ff (ctl_al_hi_ff),
        .ctl_inc_dec  (ctl_inc_dec),
        .ctl_inc_cy   (ctl_inc_cy),
        .ctl_inc_oe   (ctl_inc_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] bus;
        logic        last;
        logic [15:0] addr;
    } step_t;

    step_t       sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] gold = 16'h0000;
    logic [15:0] al = 16'h0000;
    bit          rnd_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // Control words written out by hand as {we, hi_ff, dec, cy, oe}.
    function automatic logic [4:0] exp_ctl(input logic [2:0] op, input bit s2);
        logic [4:0] c;
        c = 5'b00000;
        if (!s2) begin
            case (op)
                3'd1, 3'd5: c = 5'b10000;
                3'd2:       c = 5'b11000;
                3'd3, 3'd7: c = 5'b10011;
                3'd4, 3'd6: c = 5'b10111;
                default:    c = 5'b00000;
            endcase
        end else begin
            case (op)
                3'd5, 3'd7: c = 5'b10011;
                3'd6:       c = 5'b10111;
                default:    c = 5'b00000;
            endcase
        end
        return c;
    endfunction

    function automatic logic [15:0] next_addr(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] bus);
        case (op)
            3'd1:    return bus;
            3'd2:    return {8'hFF, bus[7:0]};
            3'd3:    return a + 16'd1;
            3'd4:    return a - 16'd1;
            3'd5:    return bus + 16'd1;
            3'd6:    return a - 16'd2;
            3'd7:    return a + 16'd2;
            default: return a;
        endcase
    endfunction

    function automatic bit two_step(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    // Presents an op, waits for acceptance, queues its expected steps; returns at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [15:0] bus, output int acc_cyc);
        int    n;
        step_t r;
        req_valid = 1'b1;
        req_op    = op;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 60);
        acc_cyc = -1;
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout op=%0d actual=not_ready required=ready", op);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_cyc = cyc;
        gold = next_addr(op, gold, bus);
        if (two_step(op)) begin
            r.ctl = exp_ctl(op, 1'b0); r.bus = bus; r.last = 1'b0; r.addr = 16'h0;
            sbq.push_back(r);
            r.ctl = exp_ctl(op, 1'b1); r.last = 1'b1; r.addr = gold;
            sbq.push_back(r);
        end else begin
            r.ctl = exp_ctl(op, 1'b0); r.bus = bus; r.last = 1'b1; r.addr = gold;
            sbq.push_back(r);
        end
        #1;
    endtask

    // Monitor: one scoreboard entry per executed (non-stalled) step.
    always @(negedge clk) begin
        logic [4:0] act;
        step_t      r;
        act = {ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe};
        if (busy && !stall) begin
            if (sbq.size() == 0) begin
                check("unexpected_step", {27'b0, act}, 32'hFFFF_FFFF);
            end else begin
                r = sbq.pop_front();
                check("step_ctl", {27'b0, act}, {27'b0, r.ctl});
                check("step_op_done", {31'b0, op_done}, {31'b0, r.last});
                check("step_req_ready", {31'b0, req_ready}, {31'b0, r.last});
                if (act[4])
                    al = act[0] ? (act[2] ? al - {15'b0, act[1]} : al + {15'b0, act[1]})
                                : (act[3] ? {8'hFF, r.bus[7:0]} : r.bus);
                if (r.last) check("latch_addr", {16'b0, al}, {16'b0, r.addr});
            end
        end else if (busy) begin
            check("stall_we", {31'b0, ctl_al_we}, 32'd0);
            check("stall_op_done", {31'b0, op_done}, 32'd0);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
        end else begin
            check("idle_ctl", {27'b0, act}, 32'd0);
            check("idle_op_done", {31'b0, op_done}, 32'd0);
            check("idle_ready", {31'b0, req_ready}, {31'b0, ~stall});
        end
    end

    always @(posedge clk) begin
        if (rnd_stall) begin
            #1;
            stall = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        int          c0, c1, c2, c3;
        logic [15:0] saved;
        int          n;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; stall = 1'b0;
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ctl", {27'b0, ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 32'd1);

        // Opcode fetch: LOAD then INC.
        issue(3'd5, 16'h1234, c0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single-step ops stream with no bubble.
        issue(3'd3, 16'h0, c0);
        issue(3'd3, 16'h0, c1);
        issue(3'd4, 16'h0, c2);
        req_valid = 1'b0;
        check("stream_gap1", c1 - c0, 32'd1);
        check("stream_gap2", c2 - c1, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // DEC2 with step2 stalled for two cycles.
        issue(3'd6, 16'h0, c0);
        req_valid = 1'b0;
        @(posedge clk);
        #1 stall = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_dec_held", {31'b0, ctl_inc_dec}, 32'd1);
            check("stall_oe_held", {31'b0, ctl_inc_oe}, 32'd1);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // LOAD_HI then NOP.
        issue(3'd2, 16'hAB12, c0);
        issue(3'd0, 16'h0, c1);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Wrap-around cases.
        issue(3'd1, 16'hFFFF, c0);
        issue(3'd3, 16'h0, c0);
        issue(3'd4, 16'h0, c0);
        issue(3'd5, 16'hFFFF, c0);
        issue(3'd6, 16'h0, c0);
        issue(3'd7, 16'h0, c0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of INC2's first step: nothing resumes.
        saved = gold;
        issue(3'd7, 16'h0, c0);
        req_valid = 1'b0;
        #1 reset = 1'b1;
        sbq.delete();
        gold = saved;
        #1;
        check("midrst_ctl", {27'b0, ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("postrst_busy", {31'b0, busy}, 32'd0);
        check("postrst_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Random ops under random stall.
        issue(3'd1, 16'h8000, c0);
        rnd_stall = 1;
        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom), c3);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        rnd_stall = 0;
        @(posedge clk);
        #2 stall = 1'b0;

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", sbq.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
